// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: decodes the IR opcode and sequences datapath strobes.
// Optional addi support is compiled in when MC_CTRL_ADDI_EN is defined.
module mc_main_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:      state_d = S_EXECUTE;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI: begin
`ifdef MC_CTRL_ADDI_EN
            state_d = S_ADDI_EXEC;
`else
            illegal_op = 1'b1;
            state_d    = S_FETCH;
`endif
          end
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // IR is not reloaded here, so the opcode seen in DECODE is still valid.
        if (opcode == OP_LW)      state_d = S_MEM_READ;
        else if (opcode == OP_SW) state_d = S_MEM_WRITE;
        else                      state_d = S_FETCH;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Reset silences every output in the same cycle, aborting any instruction.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
    end
  end

  assign state_dbg = rst ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: per-cycle expected output words queued and compared against the DUT.
// Define MC_CTRL_ADDI_EN for both bench and RTL to cover the addi path.
module tb_mc_main_control;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;

  mc_main_control #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [21:0] obs;
  assign obs = {state_dbg, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                instr_done, illegal_op};

  logic [21:0] exp_q[$];
  int n_cmp;
  int n_bad;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3,
                         MEM_WB = 4'd4, MEM_WRITE = 4'd5, EXECUTE = 4'd6, R_WB = 4'd7,
                         BRANCH = 4'd8, JUMP = 4'd9, ADDI_EXEC = 4'd10, ADDI_WB = 4'd11;

  // Output table written straight from the per-state strobe list.
  function automatic logic [21:0] spec_out(input logic [3:0] st, input logic mr, input logic ill);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, done, illo;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, done, illo} = '0;
    {asb, aop, psrc} = '0;
    case (st)
      FETCH:     begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      DECODE:    begin asb = 2'b11; illo = ill; end
      MEM_ADDR:  begin asa = 1; asb = 2'b10; end
      MEM_READ:  begin mrd = 1; iod = 1; end
      MEM_WB:    begin rw = 1; m2r = 1; done = 1; end
      MEM_WRITE: begin mwr = 1; iod = 1; done = mr; end
      EXECUTE:   begin asa = 1; aop = 2'b10; end
      R_WB:      begin rw = 1; rdst = 1; done = 1; end
      BRANCH:    begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1; end
      JUMP:      begin pw = 1; psrc = 2'b10; done = 1; end
      ADDI_EXEC: begin asa = 1; asb = 2'b10; end
      ADDI_WB:   begin rw = 1; done = 1; end
      default:   ;
    endcase
    return {st, pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, done, illo};
  endfunction

  // Driver: one clock cycle with the given mem_ready, expecting state st.
  task automatic step(input string nm, input logic mr, input logic [3:0] st, input logic ill);
    logic [21:0] e;
    logic [21:0] got;
    mem_ready = mr;
    exp_q.push_back(rst ? 22'h0 : spec_out(st, mr, ill));
    @(negedge clk);
    got = obs;
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (state got %0d exp %0d)", nm, got, e, got[21:18], e[21:18]);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input string nm, input logic [5:0] op, input int fw, input int mw);
    opcode = op;
    repeat (fw) step(nm, 1'b0, FETCH, 1'b0);
    step(nm, 1'b1, FETCH, 1'b0);
    case (op)
      6'b000000: begin
        step(nm, rnd(), DECODE, 1'b0);
        step(nm, rnd(), EXECUTE, 1'b0);
        step(nm, rnd(), R_WB, 1'b0);
      end
      6'b100011: begin
        step(nm, rnd(), DECODE, 1'b0);
        step(nm, rnd(), MEM_ADDR, 1'b0);
        repeat (mw) step(nm, 1'b0, MEM_READ, 1'b0);
        step(nm, 1'b1, MEM_READ, 1'b0);
        step(nm, rnd(), MEM_WB, 1'b0);
      end
      6'b101011: begin
        step(nm, rnd(), DECODE, 1'b0);
        step(nm, rnd(), MEM_ADDR, 1'b0);
        repeat (mw) step(nm, 1'b0, MEM_WRITE, 1'b0);
        step(nm, 1'b1, MEM_WRITE, 1'b0);
      end
      6'b000100: begin
        step(nm, rnd(), DECODE, 1'b0);
        step(nm, rnd(), BRANCH, 1'b0);
      end
      6'b000010: begin
        step(nm, rnd(), DECODE, 1'b0);
        step(nm, rnd(), JUMP, 1'b0);
      end
`ifdef MC_CTRL_ADDI_EN
      6'b001000: begin
        step(nm, rnd(), DECODE, 1'b0);
        step(nm, rnd(), ADDI_EXEC, 1'b0);
        step(nm, rnd(), ADDI_WB, 1'b0);
      end
`endif
      default: step(nm, rnd(), DECODE, 1'b1);
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1;
    opcode = 6'b000000;
    step("reset_c0", 1'b1, FETCH, 1'b0);
    step("reset_c1", 1'b1, FETCH, 1'b0);
    rst = 1'b0;
    step("reset_fetch", 1'b1, FETCH, 1'b0);
    // Reset asserted in DECODE: outputs silent, then back to FETCH.
    rst = 1'b1;
    step("reset_in_decode", 1'b1, DECODE, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_lw();
    run_instr("lw_wait2", 6'b100011, 0, 2);
    run_instr("lw_nowait", 6'b100011, 1, 0);
  endtask

  task automatic test_sw();
    run_instr("sw_wait1", 6'b101011, 1, 1);
    run_instr("sw_nowait", 6'b101011, 0, 0);
  endtask

  task automatic test_rtype();
    run_instr("rtype", 6'b000000, 0, 0);
  endtask

  task automatic test_beq();
    run_instr("beq", 6'b000100, 0, 0);
  endtask

  task automatic test_jump();
    run_instr("jump", 6'b000010, 2, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_3f", 6'b111111, 0, 0);
    run_instr("illegal_05", 6'b000101, 0, 0);
  endtask

  task automatic test_addi();
    run_instr("addi", 6'b001000, 0, 0);
  endtask

  task automatic test_mid_reset();
    opcode = 6'b000000;
    step("midrst_fetch", 1'b1, FETCH, 1'b0);
    step("midrst_decode", rnd(), DECODE, 1'b0);
    rst = 1'b1;
    step("midrst_execute", rnd(), EXECUTE, 1'b0);
    rst = 1'b0;
    run_instr("midrst_after", 6'b000100, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [0:7];
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
    ops[4] = 6'b000010; ops[5] = 6'b001000; ops[6] = 6'b111111; ops[7] = 6'b010001;
    for (int i = 0; i < 24; i++) begin
      run_instr("b2b", ops[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'b000000;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_jump();
    test_illegal();
    test_addi();
    test_mid_reset();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
